// File: rtl/argo_chan_fifo_pkg.sv
// argo_chan_fifo_pkg: head-register state encoding shared by the channel FIFO
package argo_chan_fifo_pkg;
  // bit 1: head register holds an item, bit 0: a RAM read is in flight
  typedef enum logic [1:0] {
    HEAD_EMPTY  = 2'b00,
    HEAD_FETCH  = 2'b01,
    HEAD_VALID  = 2'b10,
    HEAD_REFILL = 2'b11
  } head_state_e;
endpackage

// File: rtl/argo_chan_fifo_ram.sv
// argo_fifo_ram: simple dual-port RAM, synchronous write, registered read
//   clk, we/waddr/wdata write port, re/raddr read port, rdata registered read data
module argo_fifo_ram #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/argo_chan_fifo.sv
// argo_chan_fifo: FWFT channel FIFO with valid/ready on both sides
//   clk, rst (async active-low), flush (sync clear)
//   wr_valid/wr_ready/wr_data producer side, rd_valid/rd_ready/rd_data consumer side
//   count occupancy, almost_full/almost_empty registered flags, fifo_id constant
module argo_chan_fifo
  import argo_chan_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = 3,
  parameter int DATA_WIDTH    = 32,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 1,
  parameter int FIFO_ID       = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [15:0]           fifo_id
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF   = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE   = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  head_state_e st, st_next;
  logic live, head_v, fetch_v, move, issue, wr_fire, rd_fire;
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0] occ, count_next;
  logic [DATA_WIDTH-1:0] ram_q;
  assign fifo_id = 16'(FIFO_ID);
  argo_fifo_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk(clk), .we(wr_fire), .waddr(wptr), .wdata(wr_data),
    .re(issue), .raddr(rptr), .rdata(ram_q)
  );
  // count covers RAM, the in-flight read and the head register; occ is the part already
  // pulled out of the RAM, so count > occ means unread items remain in storage
  always_comb begin
    head_v     = st[1];
    fetch_v    = st[0];
    rd_valid   = head_v;
    wr_ready   = live && count < FULL && !flush;
    wr_fire    = wr_valid && wr_ready;
    rd_fire    = head_v && rd_ready && !flush;
    occ        = (ADDR_WIDTH+1)'(head_v) + (ADDR_WIDTH+1)'(fetch_v);
    move       = !flush && fetch_v && (!head_v || rd_fire);
    issue      = !flush && count > occ && (!fetch_v || move);
    count_next = flush ? '0 : count + (ADDR_WIDTH+1)'(wr_fire) - (ADDR_WIDTH+1)'(rd_fire);
    st_next    = flush ? HEAD_EMPTY
                       : head_state_e'({move || (head_v && !rd_fire), issue || (fetch_v && !move)});
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live         <= 1'b0;
      st           <= HEAD_EMPTY;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      rd_data      <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      live         <= 1'b1;
      st           <= st_next;
      count        <= count_next;
      almost_full  <= count_next >= AF;
      almost_empty <= count_next <= AE;
      wptr         <= flush ? '0 : wptr + ADDR_WIDTH'(wr_fire);
      rptr         <= flush ? '0 : rptr + ADDR_WIDTH'(issue);
      if (move) rd_data <= ram_q;
    end
  end
endmodule
